// File: rtl/tft_pattern_stream_pkg.sv
// tft_pkg: RGB565 colours, pattern/state types and palette helpers for tft_pattern_stream
// Contents: C_* colour constants, pattern_e (sw[3:2] modes), state_e (IDLE/RUN),
//           solid_colour() for sw[1:0] solid fills, bar_colour() for the 8-bar palette.
package tft_pkg;
  localparam logic [15:0] C_BLACK  = 16'h0000;
  localparam logic [15:0] C_RED    = 16'hF800;
  localparam logic [15:0] C_YELLOW = 16'hFFE0;
  localparam logic [15:0] C_GREEN  = 16'h07E0;
  localparam logic [15:0] C_CYAN   = 16'h07FF;
  localparam logic [15:0] C_BLUE   = 16'h001F;
  localparam logic [15:0] C_MAG    = 16'hF81F;
  localparam logic [15:0] C_WHITE  = 16'hFFFF;
  typedef enum logic [1:0] {
    PAT_SOLID = 2'b00,
    PAT_BARS  = 2'b01,
    PAT_CHECK = 2'b10,
    PAT_GRAD  = 2'b11
  } pattern_e;
  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;
  typedef enum logic {
    IDLE = S_IDLE,
    RUN  = S_RUN
  } state_e;
  function automatic logic [15:0] solid_colour(input logic [1:0] i);
    return i == 2'd0 ? C_BLACK : i == 2'd1 ? C_RED : i == 2'd2 ? C_GREEN : C_BLUE;
  endfunction
  function automatic logic [15:0] bar_colour(input logic [2:0] i);
    return i == 3'd0 ? C_RED    :
           i == 3'd1 ? C_YELLOW :
           i == 3'd2 ? C_GREEN  :
           i == 3'd3 ? C_CYAN   :
           i == 3'd4 ? C_BLUE   :
           i == 3'd5 ? C_MAG    :
           i == 3'd6 ? C_WHITE  : C_BLACK;
  endfunction
endpackage

// File: rtl/tft_pattern_stream_px.sv
// tft_pattern_px: combinational (mode, sub, x, y, offset) -> RGB565 pixel
// Ports: i_mode pattern (sw[3:2]), i_sub sub-mode (sw[1:0]), i_x/i_y raster position,
//        i_off colour-bar scroll offset, o_rgb RGB565 result.
// Build option: TFT_PATTERN_BORDER_EN forces the outermost ring of pixels to white.
module tft_pattern_px
  import tft_pkg::*;
#(
  parameter int W = 128,
  parameter int H = 160,
  localparam int XW = $clog2(W),
  localparam int YW = $clog2(H)
) (
  input  pattern_e        i_mode,
  input  logic [1:0]      i_sub,
  input  logic [XW-1:0]   i_x,
  input  logic [YW-1:0]   i_y,
  input  logic [XW-1:0]   i_off,
  output logic [15:0]     o_rgb
);
  localparam logic [XW:0] WV = (XW+1)'(W);
  localparam logic [XW:0] BV = (XW+1)'(W / 8);
  logic [XW:0]   w_sum, w_pos;
  logic [2:0]    w_bar, w_s;
  logic          w_chk;
  logic [XW-1:0] w_xy;
  logic [5:0]    w_g;
  logic [15:0]   w_grad, w_pat;
  assign w_sum  = {1'b0, i_x} + {1'b0, i_off};
  assign w_pos  = w_sum >= WV ? w_sum - WV : w_sum;
  assign w_bar  = 3'(w_pos / BV);
  assign w_s    = {1'b0, i_sub} + 3'd2;
  assign w_chk  = 1'((16'(i_x) ^ 16'(i_y)) >> w_s);
  assign w_xy   = i_x ^ XW'(i_y);
  // top six bits of y, zero-padded below when the frame is shorter than 64 lines
  assign w_g    = 6'({i_y, 6'b0} >> YW);
  assign w_grad = {i_x[XW-1 -: 5], w_g, w_xy[XW-1 -: 5]};
  always_comb begin
    w_pat = i_mode == PAT_SOLID ? solid_colour(i_sub) :
            i_mode == PAT_BARS  ? bar_colour(w_bar)   :
            i_mode == PAT_CHECK ? (w_chk ? C_WHITE : C_BLACK) : w_grad;
  end
`ifdef TFT_PATTERN_BORDER_EN
  assign o_rgb = (i_x == '0 || i_x == XW'(W - 1) || i_y == '0 || i_y == YW'(H - 1)) ? C_WHITE : w_pat;
`else
  assign o_rgb = w_pat;
`endif
endmodule

// File: rtl/tft_pattern_stream.sv
// tft_pattern_stream: scans a WxH frame and streams RGB565 test-pattern pixels over valid/ready
// Ports: clk, rst_n (async active-low); start frame request (IDLE only); sw mode, latched at start;
//        px_data/px_valid/px_ready pixel stream with px_sof at (0,0) and px_eof at (W-1,H-1);
//        busy high while a frame runs; frame_cnt completed frames (wraps).
// Build option: TFT_PATTERN_BORDER_EN (white border overlay, see tft_pattern_px).
module tft_pattern_stream
  import tft_pkg::*;
#(
  parameter int W = 128,
  parameter int H = 160,
  parameter int SCROLL_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  sw,
  output logic [15:0] px_data,
  output logic        px_valid,
  input  logic        px_ready,
  output logic        px_sof,
  output logic        px_eof,
  output logic        busy,
  output logic [15:0] frame_cnt
);
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam logic [XW-1:0] XMAX = XW'(W - 1);
  localparam logic [YW-1:0] YMAX = YW'(H - 1);
  localparam logic [XW:0]   WV   = (XW+1)'(W);
  localparam logic [XW:0]   STEP = (XW+1)'(SCROLL_STEP);
  state_e        r_state;
  logic [XW-1:0] r_x, r_off;
  logic [YW-1:0] r_y;
  logic [3:0]    r_mode;
  logic [15:0]   r_data, r_cnt;
  logic          r_valid, r_sof, r_eof;
  logic          w_idle, w_hs, w_last_x, w_last;
  logic [XW-1:0] w_nx, w_px_x, w_off_next;
  logic [YW-1:0] w_ny, w_px_y;
  logic [XW:0]   w_off_sum;
  logic [3:0]    w_mode;
  logic [15:0]   w_rgb;
  assign w_idle     = r_state == IDLE;
  assign w_hs       = r_valid && px_ready;
  assign w_last_x   = r_x == XMAX;
  assign w_last     = w_last_x && r_y == YMAX;
  assign w_nx       = w_last_x ? '0 : r_x + 1'b1;
  assign w_ny       = w_last_x ? r_y + 1'b1 : r_y;
  // the pattern generator always evaluates the pixel the output register loads next
  assign w_px_x     = w_idle ? '0 : w_nx;
  assign w_px_y     = w_idle ? '0 : w_ny;
  assign w_mode     = w_idle ? sw : r_mode;
  assign w_off_sum  = {1'b0, r_off} + STEP;
  assign w_off_next = XW'(w_off_sum >= WV ? w_off_sum - WV : w_off_sum);
  tft_pattern_px #(.W(W), .H(H)) u_px (
    .i_mode (pattern_e'(w_mode[3:2])),
    .i_sub  (w_mode[1:0]),
    .i_x    (w_px_x),
    .i_y    (w_px_y),
    .i_off  (r_off),
    .o_rgb  (w_rgb)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_off   <= '0;
      r_mode  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (w_idle) begin
      if (start) begin
        r_state <= RUN;
        r_mode  <= sw;
        r_x     <= '0;
        r_y     <= '0;
        r_data  <= w_rgb;
        r_valid <= 1'b1;
        r_sof   <= 1'b1;
        r_eof   <= 1'b0;
      end
    end else if (w_hs) begin
      if (w_last) begin
        r_state <= IDLE;
        r_x     <= '0;
        r_y     <= '0;
        r_valid <= 1'b0;
        r_sof   <= 1'b0;
        r_eof   <= 1'b0;
        r_cnt   <= r_cnt + 16'd1;
        r_off   <= w_off_next;
      end else begin
        r_x     <= w_nx;
        r_y     <= w_ny;
        r_data  <= w_rgb;
        r_sof   <= 1'b0;
        r_eof   <= w_nx == XMAX && w_ny == YMAX;
      end
    end
  end
  assign px_data   = r_data;
  assign px_valid  = r_valid;
  assign px_sof    = r_sof;
  assign px_eof    = r_eof;
  assign busy      = r_state == RUN;
  assign frame_cnt = r_cnt;
endmodule
